// File: rtl/game_scheduler.sv
// Central controller for the seven-segment games: owns game selection, splash digit,
// button gating toward the active game, per-game soft clear and idle display blanking.
module game_scheduler #(
    parameter int          NUM_GAMES     = 4,
    parameter logic [23:0] SPLASH_CYCLES = 24'd1_000_000,
    parameter logic [27:0] IDLE_CYCLES   = 28'd100_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        switch_pulse,
    input  logic [3:0]  btn_pulse,
    input  logic [15:0] game_values,
    output logic [1:0]  game_sel,
    output logic [15:0] game_btn,
    output logic [3:0]  game_clr,
    output logic [3:0]  display_value,
    output logic        splash_active
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_SPLASH = 2'd1,
        ST_SLEEP  = 2'd2
    } state_t;

    localparam logic [1:0] LAST_SEL = 2'(NUM_GAMES - 1);
    localparam logic [3:0] BLANK    = 4'd12;

    state_t      state_q, state_d;
    logic [1:0]  game_sel_q, game_sel_d;
    logic [15:0] game_btn_q, game_btn_d;
    logic [3:0]  game_clr_q, game_clr_d;
    logic [3:0]  display_value_q, display_value_d;
    logic        splash_active_q, splash_active_d;
    logic [23:0] splash_cnt_q, splash_cnt_d;
    logic [27:0] idle_cnt_q, idle_cnt_d;
    logic [1:0]  next_sel_s;
    logic        any_btn_s;

    // Next-state and next-output logic for the RUN / SPLASH / SLEEP controller
    always_comb begin
        state_d         = state_q;
        game_sel_d      = game_sel_q;
        game_btn_d      = 16'd0;
        game_clr_d      = 4'd0;
        display_value_d = display_value_q;
        splash_cnt_d    = splash_cnt_q;
        idle_cnt_d      = idle_cnt_q;
        next_sel_s      = (game_sel_q == LAST_SEL) ? 2'd0 : game_sel_q + 2'd1;
        any_btn_s       = |btn_pulse;

        case (state_q)
            ST_RUN: begin
                display_value_d = game_values[{game_sel_q, 2'b00} +: 4];
                if (switch_pulse) begin
                    // A switch wins over any button pulse in the same cycle
                    game_sel_d   = next_sel_s;
                    game_clr_d   = 4'b0001 << next_sel_s;
                    splash_cnt_d = 24'd0;
                    idle_cnt_d   = 28'd0;
                    state_d      = ST_SPLASH;
                end else if (any_btn_s) begin
                    game_btn_d[{game_sel_q, 2'b00} +: 4] = btn_pulse;
                    idle_cnt_d = 28'd0;
                end else if (idle_cnt_q == IDLE_CYCLES - 28'd1) begin
                    idle_cnt_d = 28'd0;
                    state_d    = ST_SLEEP;
                end else begin
                    idle_cnt_d = idle_cnt_q + 28'd1;
                end
            end
            ST_SPLASH: begin
                display_value_d = {2'b00, game_sel_q} + 4'd1;
                if (switch_pulse) begin
                    game_sel_d   = next_sel_s;
                    game_clr_d   = 4'b0001 << next_sel_s;
                    splash_cnt_d = 24'd0;
                end else if (splash_cnt_q == SPLASH_CYCLES - 24'd1) begin
                    idle_cnt_d = 28'd0;
                    state_d    = ST_RUN;
                end else begin
                    splash_cnt_d = splash_cnt_q + 24'd1;
                end
            end
            ST_SLEEP: begin
                display_value_d = BLANK;
                // The waking event is consumed and never reaches a game
                if (switch_pulse || any_btn_s) begin
                    idle_cnt_d = 28'd0;
                    state_d    = ST_RUN;
                end else begin
                    idle_cnt_d = idle_cnt_q;
                end
            end
            default: begin
                display_value_d = BLANK;
                idle_cnt_d      = 28'd0;
                state_d         = ST_RUN;
            end
        endcase

        splash_active_d = (state_d == ST_SPLASH);
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q         <= ST_RUN;
            game_sel_q      <= 2'd0;
            game_btn_q      <= 16'd0;
            game_clr_q      <= 4'd0;
            display_value_q <= BLANK;
            splash_active_q <= 1'b0;
            splash_cnt_q    <= 24'd0;
            idle_cnt_q      <= 28'd0;
        end else begin
            state_q         <= state_d;
            game_sel_q      <= game_sel_d;
            game_btn_q      <= game_btn_d;
            game_clr_q      <= game_clr_d;
            display_value_q <= display_value_d;
            splash_active_q <= splash_active_d;
            splash_cnt_q    <= splash_cnt_d;
            idle_cnt_q      <= idle_cnt_d;
        end
    end

    assign game_sel      = game_sel_q;
    assign game_btn      = game_btn_q;
    assign game_clr      = game_clr_q;
    assign display_value = display_value_q;
    assign splash_active = splash_active_q;

endmodule

// File: tb/tb_game_scheduler.sv
// Directed plus randomized bench for game_scheduler, checked against a cycle-level
// behavioural model built from splash countdown / quiet-cycle counting rules.
module tb_game_scheduler;

    localparam int NG  = 4;
    localparam int SPL = 4;
    localparam int IDL = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        switch_pulse;
    logic [3:0]  btn_pulse;
    logic [15:0] game_values;
    logic [1:0]  game_sel;
    logic [15:0] game_btn;
    logic [3:0]  game_clr;
    logic [3:0]  display_value;
    logic        splash_active;

    always #5 clk = ~clk;

    game_scheduler #(
        .NUM_GAMES    (NG),
        .SPLASH_CYCLES(24'd4),
        .IDLE_CYCLES  (28'd8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .switch_pulse (switch_pulse),
        .btn_pulse    (btn_pulse),
        .game_values  (game_values),
        .game_sel     (game_sel),
        .game_btn     (game_btn),
        .game_clr     (game_clr),
        .display_value(display_value),
        .splash_active(splash_active)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: splash is a countdown of remaining cycles, sleep is a flag
    int          m_sel, m_left, m_quiet;
    bit          m_asleep;
    logic [15:0] e_btn;
    logic [3:0]  e_clr, e_disp;
    logic        e_spl;
    int          game_val[4] = '{5, 1, 2, 3};

    task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic accept_switch();
        m_sel  = (m_sel + 1) % NG;
        e_clr  = 4'b0001 << m_sel;
        m_left = SPL;
    endtask

    task automatic model_step();
        logic [15:0] wide_btn;
        e_btn = 16'd0;
        e_clr = 4'd0;
        if (!rst_n) begin
            m_sel = 0; m_left = 0; m_asleep = 1'b0; m_quiet = 0;
            e_disp = 4'd12;
        end else if (m_left > 0) begin
            e_disp = 4'(m_sel + 1);
            if (switch_pulse) accept_switch();
            else begin
                m_left--;
                if (m_left == 0) m_quiet = 0;
            end
        end else if (m_asleep) begin
            e_disp = 4'd12;
            if (switch_pulse || btn_pulse != 4'd0) begin
                m_asleep = 1'b0;
                m_quiet  = 0;
            end
        end else begin
            e_disp = game_values[4*m_sel +: 4];
            if (switch_pulse) begin
                accept_switch();
                m_quiet = 0;
            end else if (btn_pulse != 4'd0) begin
                wide_btn = {12'd0, btn_pulse};
                e_btn    = wide_btn << (4 * m_sel);
                m_quiet  = 0;
            end else if (m_quiet == IDL - 1) begin
                m_asleep = 1'b1;
                m_quiet  = 0;
            end else begin
                m_quiet++;
            end
        end
        e_spl = (m_left > 0);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_val("model_sel",    {14'd0, game_sel},      16'(m_sel));
        check_val("model_btn",    game_btn,               e_btn);
        check_val("model_clr",    {12'd0, game_clr},      {12'd0, e_clr});
        check_val("model_disp",   {12'd0, display_value}, {12'd0, e_disp});
        check_val("model_splash", {15'd0, splash_active}, {15'd0, e_spl});
    endtask

    initial begin
        logic [3:0] clr_seq[4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
        rst_n = 1'b0; switch_pulse = 1'b0; btn_pulse = 4'd0; game_values = 16'h3215;
        tick();
        check_val("reset_disp", {12'd0, display_value}, 16'd12);
        tick();
        rst_n = 1'b1;
        tick();
        check_val("first_disp", {12'd0, display_value}, 16'd5);
        check_val("first_sel", {14'd0, game_sel}, 16'd0);

        btn_pulse = 4'b0010;
        tick();
        btn_pulse = 4'd0;
        check_val("btn_route", game_btn, 16'h0002);
        tick();
        check_val("btn_single", game_btn, 16'h0000);

        for (int k = 0; k < 4; k++) begin
            switch_pulse = 1'b1;
            tick();
            switch_pulse = 1'b0;
            check_val("clr_seq", {12'd0, game_clr}, {12'd0, clr_seq[k]});
            check_val("sel_seq", {14'd0, game_sel}, 16'((k + 1) % 4));
            tick();
            check_val("splash_digit", {12'd0, display_value}, 16'(((k + 1) % 4) + 1));
            repeat (5) tick();
            check_val("post_splash", {12'd0, display_value}, 16'(game_val[(k + 1) % 4]));
        end

        switch_pulse = 1'b1; btn_pulse = 4'b0001;
        tick();
        switch_pulse = 1'b0; btn_pulse = 4'd0;
        check_val("switch_wins_btn", game_btn, 16'h0000);
        check_val("switch_wins_sel", {14'd0, game_sel}, 16'd1);
        check_val("switch_splash", {15'd0, splash_active}, 16'd1);
        btn_pulse = 4'b0001;
        tick();
        btn_pulse = 4'd0;
        check_val("splash_drop_btn", game_btn, 16'h0000);
        repeat (6) tick();

        repeat (10) tick();
        check_val("sleep_disp", {12'd0, display_value}, 16'd12);
        btn_pulse = 4'b0001;
        tick();
        btn_pulse = 4'd0;
        check_val("wake_no_btn", game_btn, 16'h0000);
        check_val("wake_sel", {14'd0, game_sel}, 16'd1);
        tick();
        check_val("wake_disp", {12'd0, display_value}, 16'd1);

        switch_pulse = 1'b1;
        tick();
        switch_pulse = 1'b0;
        check_val("pre_reset_sel", {14'd0, game_sel}, 16'd2);
        tick();
        rst_n = 1'b0;
        tick();
        check_val("rst_sel", {14'd0, game_sel}, 16'd0);
        check_val("rst_splash", {15'd0, splash_active}, 16'd0);
        check_val("rst_disp", {12'd0, display_value}, 16'd12);
        rst_n = 1'b1;
        tick();
        check_val("rst_resume", {12'd0, display_value}, 16'd5);

        repeat (1500) begin
            rst_n        = ($urandom_range(0, 199) != 0);
            switch_pulse = ($urandom_range(0, 15) == 0);
            btn_pulse    = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'd0;
            if ($urandom_range(0, 7) == 0) game_values = 16'($urandom);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
